// File: rtl/dequant_pipe.sv
// Table-driven dequantizer: LANES coefficients per beat, product saturated to OUT_W bits.
// Latency 2 cycles; stalls hold outputs, and in_ready drops once two beats are buffered.
module dequant_pipe #(
  parameter int LANES      = 8,
  parameter int IN_W       = 8,
  parameter int Q_W        = 7,
  parameter int OUT_W      = 12,
  parameter int NUM_TABLES = 2,
  localparam int SEL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tbl_wr_en,
  input  logic [SEL_W-1:0]       tbl_wr_sel,
  input  logic [5:0]             tbl_wr_addr,
  input  logic [Q_W-1:0]         tbl_wr_data,
  input  logic [SEL_W-1:0]       tbl_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  output logic                   out_last
);

  localparam int BEATS  = 64 / LANES;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int IDX_W  = SEL_W + 6;
  localparam int PROD_W = IN_W + Q_W + 1;
  localparam int CMP_W  = ((PROD_W > OUT_W) ? PROD_W : OUT_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [Q_W-1:0]           tbl_mem [NUM_TABLES*64];
  logic [IDX_W-1:0]         wr_idx;
  logic [IDX_W-1:0]         rd_idx  [LANES];
  logic [Q_W-1:0]           rd_q    [LANES];

  logic [CNT_W-1:0]         beat_cnt;
  logic [SEL_W-1:0]         blk_tbl;
  logic [SEL_W-1:0]         cur_tbl;
  logic                     load2;
  logic                     accept;

  logic                     s1_valid;
  logic                     s1_last;
  logic signed [IN_W-1:0]   s1_coef [LANES];
  logic [Q_W-1:0]           s1_q    [LANES];

  logic signed [CMP_W-1:0]  mul_a   [LANES];
  logic signed [CMP_W-1:0]  mul_b   [LANES];
  logic signed [CMP_W-1:0]  prod    [LANES];
  logic [LANES*OUT_W-1:0]   nxt_data;
  logic [LANES-1:0]         nxt_sat;

  assign load2    = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || load2);
  assign accept   = in_valid && in_ready;
  // Beat 0 reads the live selector so the whole block uses the table chosen at its start.
  assign cur_tbl  = (beat_cnt == '0) ? tbl_sel : blk_tbl;
  assign wr_idx   = {tbl_wr_sel, tbl_wr_addr};

  // Table storage survives reset; a write lands at the edge, so a same-cycle read sees the old entry.
  always_ff @(posedge clk) begin
    if (tbl_wr_en && (int'(tbl_wr_sel) < NUM_TABLES)) begin
      tbl_mem[wr_idx] <= tbl_wr_data;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_idx[l] = {cur_tbl, 6'(int'(beat_cnt) * LANES + l)};
      rd_q[l]   = (int'(cur_tbl) < NUM_TABLES) ? tbl_mem[rd_idx[l]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      beat_cnt <= '0;
      blk_tbl  <= '0;
    end else begin
      if (!s1_valid || load2) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_last <= (beat_cnt == LAST_BEAT);
        for (int l = 0; l < LANES; l++) begin
          s1_coef[l] <= in_data[(LANES-1-l)*IN_W +: IN_W];
          s1_q[l]    <= rd_q[l];
        end
        if (beat_cnt == '0) begin
          blk_tbl <= tbl_sel;
        end
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  // Products are formed one bit wider than needed so the clamp compares the exact value.
  always_comb begin
    nxt_data = '0;
    nxt_sat  = '0;
    for (int l = 0; l < LANES; l++) begin
      mul_a[l] = CMP_W'(s1_coef[l]);
      mul_b[l] = CMP_W'({1'b0, s1_q[l]});
      prod[l]  = mul_a[l] * mul_b[l];
      if (prod[l] > SAT_MAX) begin
        nxt_data[(LANES-1-l)*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        nxt_sat[LANES-1-l]                   = 1'b1;
      end else if (prod[l] < SAT_MIN) begin
        nxt_data[(LANES-1-l)*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        nxt_sat[LANES-1-l]                   = 1'b1;
      end else begin
        nxt_data[(LANES-1-l)*OUT_W +: OUT_W] = prod[l][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      out_last  <= 1'b0;
    end else if (load2) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        out_data <= nxt_data;
        out_sat  <= nxt_sat;
      end
    end
  end

endmodule

// File: tb/tb_dequant_pipe.sv
// Directed bench for dequant_pipe: vector table for the multiply/clamp, hand sequences for flow control.
module tb_dequant_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_wr_en;
  logic [0:0]  tbl_wr_sel;
  logic [5:0]  tbl_wr_addr;
  logic [6:0]  tbl_wr_data;
  logic [0:0]  tbl_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [7:0]  out_sat;
  logic        out_last;

  dequant_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_sel  (tbl_wr_sel),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
    .tbl_sel     (tbl_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] d;
    logic [7:0]  s;
    logic        l;
    logic [31:0] c;
  } ob_t;

  typedef struct {
    logic signed [7:0] coef;
    logic [6:0]        q;
    logic [11:0]       exp_out;
    logic              exp_sat;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   last_acc_cyc = 0;
  ob_t  out_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_q.push_back({out_data, out_sat, out_last, 32'(cyc)});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout, required event within bound", name);
  endtask

  task automatic tbl_write(input logic [0:0] sel, input int addr, input int data);
    tbl_wr_en   = 1'b1;
    tbl_wr_sel  = sel;
    tbl_wr_addr = 6'(addr);
    tbl_wr_data = 7'(data);
    @(posedge clk); #1;
    tbl_wr_en   = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [0:0] sel);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    tbl_sel  = sel;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!acc) timeout_fail("send_beat");
    n_acc++;
  endtask

  task automatic wait_out(input int n, input string name);
    int k = 0;
    while (out_q.size() < n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (out_q.size() < n) timeout_fail(name);
  endtask

  task automatic pop_out(output ob_t ob);
    if (out_q.size() > 0) ob = out_q.pop_front();
    else ob = '0;
  endtask

  vec_t        vt [14];
  ob_t         ob;
  logic [95:0] e;
  logic [95:0] held;
  int          first_acc;

  initial begin
    vt[0]  = '{8'sd127,  7'd87,  12'h7FF, 1'b1};
    vt[1]  = '{-8'sd128, 7'd87,  12'h800, 1'b1};
    vt[2]  = '{-8'sd3,   7'd10,  12'hFE2, 1'b0};
    vt[3]  = '{8'sd2,    7'd1,   12'h002, 1'b0};
    vt[4]  = '{8'sd16,   7'd127, 12'h7F0, 1'b0};
    vt[5]  = '{8'sd127,  7'd127, 12'h7FF, 1'b1};
    vt[6]  = '{-8'sd128, 7'd127, 12'h800, 1'b1};
    vt[7]  = '{-8'sd16,  7'd127, 12'h810, 1'b0};
    vt[8]  = '{8'sd23,   7'd89,  12'h7FF, 1'b0};
    vt[9]  = '{8'sd32,   7'd64,  12'h7FF, 1'b1};
    vt[10] = '{-8'sd32,  7'd64,  12'h800, 1'b0};
    vt[11] = '{-8'sd41,  7'd50,  12'h800, 1'b1};
    vt[12] = '{8'sd0,    7'd127, 12'h000, 1'b0};
    vt[13] = '{-8'sd128, 7'd0,   12'h000, 1'b0};

    rst = 1'b1; tbl_wr_en = 1'b0; tbl_wr_sel = '0; tbl_wr_addr = '0; tbl_wr_data = '0;
    tbl_sel = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_out_data", out_data, 0);
    chk("rel_out_sat", out_sat, 0);
    chk("rel_out_last", out_last, 0);
    @(posedge clk); #1;

    // Basic block: q[i] = i+1, all inputs 2.
    for (int i = 0; i < 64; i++) tbl_write(0, i, i + 1);
    for (int r = 0; r < 8; r++) begin
      send_beat({8{8'sd2}}, 0);
      if (r == 0) first_acc = last_acc_cyc;
    end
    in_valid = 1'b0;
    wait_out(8, "basic_wait");
    for (int r = 0; r < 8; r++) begin
      pop_out(ob);
      for (int l = 0; l < 8; l++) e[(7-l)*12 +: 12] = 12'(2 * (8*r + l + 1));
      chk("basic_data", ob.d, e);
      chk("basic_sat_last", {ob.s, ob.l}, {8'h00, r == 7});
      if (r == 0) chk("basic_latency", int'(ob.c) - first_acc, 2);
    end

    // Backpressure: stall 5 cycles once beat 2 has been accepted.
    n_acc = 0;
    fork
      begin
        for (int r = 0; r < 8; r++) send_beat({8{8'(r + 1)}}, 0);
        in_valid = 1'b0;
      end
      begin
        wait (n_acc == 3);
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        held = out_data;
        repeat (4) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("bp_hold_data", out_data, held);
          chk("bp_hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_out(8, "bp_wait");
    for (int r = 0; r < 8; r++) begin
      pop_out(ob);
      for (int l = 0; l < 8; l++) e[(7-l)*12 +: 12] = 12'((r + 1) * (8*r + l + 1));
      chk("bp_data", ob.d, e);
      chk("bp_last", ob.l, r == 7);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_dup", out_q.size(), 0);

    // Multiply and clamp vectors, checked on beat 0 of a block.
    for (int v = 0; v < 14; v++) begin
      for (int i = 0; i < 8; i++) tbl_write(0, i, int'(vt[v].q));
      send_beat({8{vt[v].coef}}, 0);
      for (int r = 1; r < 8; r++) send_beat('0, 0);
      in_valid = 1'b0;
      wait_out(8, $sformatf("vec%0d_wait", v));
      pop_out(ob);
      chk($sformatf("vec%0d_data", v), ob.d, {8{vt[v].exp_out}});
      chk($sformatf("vec%0d_sat", v), ob.s, vt[v].exp_sat ? 8'hFF : 8'h00);
      repeat (7) pop_out(ob);
    end

    // Table selection latched on beat 0 only.
    for (int i = 0; i < 64; i++) begin
      tbl_write(1, i, 16);
      tbl_write(0, i, 1);
    end
    for (int r = 0; r < 8; r++) send_beat({8{8'sd5}}, (r < 3) ? 1'b1 : 1'b0);
    for (int r = 0; r < 8; r++) send_beat({8{8'sd5}}, 0);
    in_valid = 1'b0;
    wait_out(16, "sel_wait");
    for (int r = 0; r < 16; r++) begin
      pop_out(ob);
      chk((r < 8) ? "sel_tbl1" : "sel_tbl0", ob.d, (r < 8) ? {8{12'd80}} : {8{12'd5}});
    end

    // Write in the same cycle as beat 1 is accepted: old value used.
    send_beat({8{8'sd4}}, 0);
    tbl_wr_en = 1'b1; tbl_wr_sel = 0; tbl_wr_addr = 6'd8; tbl_wr_data = 7'd9;
    send_beat({8{8'sd4}}, 0);
    tbl_wr_en = 1'b0;
    for (int r = 2; r < 8; r++) send_beat({8{8'sd4}}, 0);
    for (int r = 0; r < 8; r++) send_beat({8{8'sd4}}, 0);
    in_valid = 1'b0;
    wait_out(16, "haz_wait");
    for (int r = 0; r < 16; r++) begin
      pop_out(ob);
      e = {8{12'd4}};
      if (r == 9) e[95:84] = 12'd36;
      chk((r < 8) ? "haz_old" : "haz_new", ob.d, e);
    end

    // Reset at beat 4: counter and selection restart, tables retained.
    for (int r = 0; r < 4; r++) send_beat({8{8'sd3}}, 1);
    in_data = {8{8'sd3}};
    rst = 1'b1;
    @(negedge clk);
    chk("mr_in_ready_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr_out_valid", out_valid, 0);
    @(posedge clk); #1;
    out_q.delete();
    for (int r = 0; r < 8; r++) send_beat({8{8'sd3}}, 0);
    in_valid = 1'b0;
    wait_out(8, "mr_wait");
    for (int r = 0; r < 8; r++) begin
      pop_out(ob);
      e = {8{12'd3}};
      if (r == 1) e[95:84] = 12'd27;
      chk("mr_data", ob.d, e);
      chk("mr_last", ob.l, r == 7);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("mr_no_extra", out_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
